// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: issues word fetches to a variable-latency imem
// and buffers returned words with their PC+4 in an in-order FIFO for IF/ID.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pcAdd4
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W = $clog2(DEPTH + MAX_OUT + 1);

    typedef struct packed {
        logic [31:0] pcAdd4;
        logic [31:0] inst;
    } entry_t;

    entry_t             qMem [DEPTH];
    logic [31:0]        fetchPc, respPc;
    logic [PTR_W-1:0]   headPtr, tailPtr;
    logic [CNT_W-1:0]   count;
    logic [OUT_W-1:0]   outstanding, discard;
    logic [SUM_W-1:0]   credit;
    logic               accept, push, pop, notEmpty;

    // Credits cover both buffered words and in-flight requests, so a response
    // always has a free slot and rvalid never needs back-pressure.
    assign credit    = SUM_W'(count) + SUM_W'(outstanding);
    assign imem_req  = !rst && !redirect && (outstanding < OUT_W'(MAX_OUT))
                       && (credit < SUM_W'(DEPTH));
    assign imem_addr = {fetchPc[31:2], 2'b00};

    assign notEmpty  = (count != '0);
    assign accept    = imem_req && imem_gnt;
    assign push      = imem_rvalid && (discard == '0) && !redirect;
    assign pop       = deq && notEmpty && !redirect;

    assign inst_valid = notEmpty;
    assign inst       = notEmpty ? qMem[headPtr].inst   : 32'h0;
    assign pcAdd4     = notEmpty ? qMem[headPtr].pcAdd4 : 32'h0;

    always_ff @(posedge clk) begin
        if (push)
            qMem[tailPtr] <= '{pcAdd4: respPc + 32'd4, inst: imem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            headPtr     <= '0;
            tailPtr     <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            // Every request still in flight (minus one answered now) is stale.
            fetchPc     <= redirect_pc;
            respPc      <= redirect_pc;
            headPtr     <= '0;
            tailPtr     <= '0;
            count       <= '0;
            outstanding <= outstanding - OUT_W'(imem_rvalid);
            discard     <= outstanding - OUT_W'(imem_rvalid);
        end else begin
            if (accept)
                fetchPc <= fetchPc + 32'd4;

            case ({accept, imem_rvalid})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (imem_rvalid && (discard != '0))
                discard <= discard - OUT_W'(1);

            if (push) begin
                tailPtr <= tailPtr + PTR_W'(1);
                respPc  <= respPc + 32'd4;
            end
            if (pop)
                headPtr <= headPtr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue; the bench plays the instruction memory
// cycle by cycle through a table of hand-computed vectors.
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        deq = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pcAdd4;

    inst_fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .inst_valid(inst_valid), .inst(inst), .pcAdd4(pcAdd4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        deq, redir;
        logic [31:0] rpc;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] inst, pc4;
    } vec_t;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
    int nVec = 0;
    int nErr = 0;
    int benchOut = 0;

    function automatic logic [31:0] W(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input logic d, input logic r, input logic [31:0] rp,
                                input logic g, input logic v, input logic [31:0] rd,
                                input logic eReq, input logic [31:0] eAddr,
                                input logic eIv, input logic [31:0] eInst,
                                input logic [31:0] ePc4);
        vec_t t;
        t.deq = d; t.redir = r; t.rpc = rp; t.gnt = g; t.rv = v; t.rdata = rd;
        t.req = eReq; t.addr = eAddr; t.iv = eIv; t.inst = eInst; t.pc4 = ePc4;
        return t;
    endfunction

    // Responses must follow grants; track the memory side independently.
    always @(posedge clk or posedge rst) begin
        if (rst) benchOut <= 0;
        else begin
            if (imem_rvalid)
                assert (benchOut != 0) else $error("rvalid without outstanding grant");
            benchOut <= benchOut + ((imem_req && imem_gnt) ? 1 : 0) - (imem_rvalid ? 1 : 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic d, input logic g, input logic v, input logic [31:0] rd);
        @(negedge clk);
        deq = d; imem_gnt = g; imem_rvalid = v; imem_rdata = rd; redirect = 1'b0;
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // deq, redir, rpc, gnt, rv, rdata | req, addr, iv, inst, pc4
        vecs.push_back(mk(1,0,0,1,0,0,             1,32'h0,1'b0,0,0));
        vecs.push_back(mk(1,0,0,1,1,W(32'h0),      1,32'h4,1'b0,0,0));
        vecs.push_back(mk(1,0,0,1,1,W(32'h4),      1,32'h8,1'b1,W(32'h0),32'h4));
        vecs.push_back(mk(1,0,0,1,1,W(32'h8),      1,32'hC,1'b1,W(32'h4),32'h8));
        vecs.push_back(mk(0,0,0,0,1,W(32'hC),      1,32'h10,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(0,0,0,1,0,0,             1,32'h10,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(0,0,0,1,0,0,             1,32'h14,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(0,0,0,1,1,W(32'h10),     0,32'h18,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(0,0,0,1,1,W(32'h14),     0,32'h18,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(0,0,0,1,0,0,             0,32'h18,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(1,0,0,1,0,0,             0,32'h18,1'b1,W(32'h8),32'hC));
        vecs.push_back(mk(1,0,0,1,0,0,             1,32'h18,1'b1,W(32'hC),32'h10));
        vecs.push_back(mk(0,0,0,1,0,0,             1,32'h1C,1'b1,W(32'h10),32'h14));
        vecs.push_back(mk(1,1,32'h40,1,0,0,        0,32'h20,1'b1,W(32'h10),32'h14));
        vecs.push_back(mk(1,0,0,1,1,JUNK,          0,32'h40,1'b0,0,0));
        vecs.push_back(mk(1,0,0,1,1,JUNK,          1,32'h40,1'b0,0,0));
        vecs.push_back(mk(1,0,0,0,1,W(32'h40),     1,32'h44,1'b0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,             1,32'h44,1'b1,W(32'h40),32'h44));
        vecs.push_back(mk(0,0,0,1,0,0,             1,32'h44,1'b1,W(32'h40),32'h44));
        vecs.push_back(mk(0,0,0,1,0,0,             1,32'h48,1'b1,W(32'h40),32'h44));
        // redirect + rvalid + deq together with two in flight
        vecs.push_back(mk(1,1,32'h100,1,1,JUNK,    0,32'h4C,1'b1,W(32'h40),32'h44));
        vecs.push_back(mk(1,0,0,0,0,0,             1,32'h100,1'b0,0,0));
        vecs.push_back(mk(0,1,32'h200,1,0,0,       0,32'h100,1'b0,0,0));
        vecs.push_back(mk(0,0,0,1,1,JUNK,          1,32'h200,1'b0,0,0));
        vecs.push_back(mk(0,0,0,0,1,W(32'h200),    1,32'h204,1'b0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,             1,32'h204,1'b1,W(32'h200),32'h204));
        vecs.push_back(mk(1,0,0,0,0,0,             1,32'h204,1'b0,0,0));
        // 32-bit PC wrap
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0, 0,32'h204,1'b0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0,             1,32'hFFFF_FFFC,1'b0,0,0));
        vecs.push_back(mk(0,0,0,0,1,W(32'hFFFF_FFFC), 1,32'h0,1'b0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,             1,32'h0,1'b1,W(32'hFFFF_FFFC),32'h0));

        repeat (2) @(negedge clk);
        chk("rst_req",  {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc4",  pcAdd4, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            deq = vecs[i].deq; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
            #1;
            nVec++;
            if ({imem_req, imem_addr, inst_valid, inst, pcAdd4} !==
                {vecs[i].req, vecs[i].addr, vecs[i].iv, vecs[i].inst, vecs[i].pc4}) begin
                nErr++;
                $display("FAIL vec%0d: got req=%b addr=%h v=%b inst=%h pc4=%h expected req=%b addr=%h v=%b inst=%h pc4=%h",
                         i, imem_req, imem_addr, inst_valid, inst, pcAdd4,
                         vecs[i].req, vecs[i].addr, vecs[i].iv, vecs[i].inst, vecs[i].pc4);
            end
        end

        // Build count=3, outstanding=1, then pulse rst mid-operation.
        drive(0, 1, 0, 32'h0);
        drive(0, 1, 1, W(32'h0));
        drive(0, 1, 1, W(32'h4));
        drive(0, 1, 1, W(32'h8));
        drive(0, 0, 0, 32'h0);
        chk("pre_rst_valid", {31'h0, inst_valid}, 32'h1);
        chk("pre_rst_inst", inst, W(32'h0));
        chk("pre_rst_addr", imem_addr, 32'h10);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("async_rst_req", {31'h0, imem_req}, 32'h0);
        chk("async_rst_inst", inst, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 32'h0);
            chk("post_rst_no_stale", {31'h0, inst_valid}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
